seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Iterative restoring shift-subtract divider; the division counterpart of the shift-add multiplier.
//  Sits beside the multiplier in the CPU's multi-cycle ALU and serves div/divu/rem/remu.
//  Produces one quotient bit per clock, then applies a single sign-fix cycle.
//  Uses a start/busy/fin handshake with registered outputs.
// PARAMETERS
//  WIDTH   32   operand, quotient and remainder width in bits (>=4)
// PORTS
//  clk          in   1      system clock, rising-edge active
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      request a division; sampled only while idle
//  is_signed    in   1      1 = two's-complement operands, 0 = unsigned; sampled with start
//  dividend_in  in   WIDTH  dividend; sampled with start
//  divisor_in   in   WIDTH  divisor; sampled with start
//  quotient     out  WIDTH  result quotient; held until the next accepted start
//  remainder    out  WIDTH  result remainder; held until the next accepted start
//  busy         out  1      high from the edge that accepts start until fin falls
//  fin          out  1      single-cycle pulse: results valid
//  div_zero     out  1      divisor was 0; valid with fin, held like quotient
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; quotient=0, remainder=0, busy=0, fin=0, div_zero=0, count=0.
//  - States:
//      IDLE -> RUN   on start && divisor_in!=0
//      IDLE -> FIX   on start && divisor_in==0
//      RUN  -> FIX   when count==WIDTH-1
//      FIX  -> DONE  always
//      DONE -> IDLE  always
//  - Accept edge E0 (IDLE, start=1):
//      * Latch |dividend| and |divisor|. Take magnitudes only when is_signed=1 and MSB=1; else use raw values.
//      * Latch sign_q = is_signed & (dvd_msb ^ dvs_msb), sign_r = is_signed & dvd_msb.
//      * Clear the partial remainder (WIDTH+1 bits).
//      * Set busy=1, fin=0, div_zero=(divisor_in==0).
//  - RUN, one edge per bit, MSB first:
//      * r' = {r, q_msb}. The q shift register holds the dividend magnitude and shifts left.
//      * If r' >= divisor: r = r'-divisor, q_lsb = 1; else r = r', q_lsb = 0.
//      * count increments; exactly WIDTH RUN edges occur.
//  - FIX:
//      * quotient = sign_q ? -q : q; remainder = sign_r ? -r[WIDTH-1:0] : r[WIDTH-1:0].
//      * Set fin=1.
//      * Divide-by-zero path: quotient = all ones; remainder = raw dividend_in as latched (no sign fix); div_zero=1.
//  - DONE: fin=0, busy=0, return to IDLE. Results and div_zero persist.
//  - Latency:
//      * Normal: fin is high in the cycle after edge E0+WIDTH+1 (33 edges for WIDTH=32).
//      * Div-by-zero: fin is high after E0+1.
//      * Throughput: a new start is accepted 2 edges after fin rises (on the edge after DONE).
//  - Boundary rules:
//      * Signed MIN / -1: magnitude 2^(WIDTH-1) is held in WIDTH bits unsigned, so quotient=MIN and remainder=0. No flag.
//      * Dividend 0: quotient=0, remainder=0, full latency.
//      * divisor > dividend (unsigned): quotient=0, remainder=dividend.
//      * start while busy: ignored; the operation in progress is unaffected.
//      * start held high continuously: a new division is accepted on every return to IDLE.
//      * rst asserted mid-operation: immediate return to reset values; no fin pulse.
//      * Operand inputs may change freely after E0.
// STRUCTURE
//  - Shared ALU package: state encoding localparams (IDLE, RUN, FIX, DONE); DIV_ZERO_QUOTIENT = all ones.
//  - The package is shared with the multiplier control so the ALU sequencer decodes both uniformly.
//  - One natural sub-module, div_step: combinational restoring step.
//      * Inputs: r, q_msb, divisor.
//      * Outputs: next r, q bit.
//      * Unit-testable in isolation.
//  - Counter width: $clog2(WIDTH).
//  - Remainder register is WIDTH+1 bits so the compare needs no overflow handling.
// TESTING
//  1 Unsigned 100/7, is_signed=0 -> quotient=14, remainder=2, div_zero=0. fin exactly one cycle, 33 edges after E0.
//  2 Signed -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
//    Unsigned same operands -> quotient=0x7FFFFFFC, remainder=1.
//  3 5/0 -> div_zero=1, quotient=0xFFFFFFFF, remainder=5; fin after 2nd edge; busy low after the 3rd edge.
//  4 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero=0.
//  5 Start 1000/3; pulse start again with 9/9 at edge E5 -> ignored, result quotient=333, remainder=1.
//    Then start held -> back-to-back 9/9 gives quotient=1, remainder=0.
//  6 Assert rst at edge E10 of a division -> all outputs 0 asynchronously, no fin.
//    A new 6/4 after release -> quotient=1, remainder=2.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared multi-cycle ALU definitions: sequencer state encoding and fixed result constants.
// Used by both the shift-subtract divider and the shift-add multiplier control.
// No logic; types and constants only.
package seq_divider_pkg;

   // Sequencer states decoded uniformly by the ALU for multiply and divide
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Quotient returned on divide-by-zero (all ones); sliced to the operand width, up to 64 bits
   localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle, consumed only while the divider runs.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   r,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   r_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic           ge;

   // Restoring step; r's top bit is always clear in use, folding it into the compare keeps the step correct for any r
   always_comb begin
      shifted = {r[WIDTH-1:0], q_msb};
      ge      = r[WIDTH] | (shifted >= {1'b0, divisor});
      q_bit   = ge;
      r_next  = ge ? (shifted - {1'b0, divisor}) : shifted;
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for div/divu/rem/remu: one quotient bit per clock plus a sign-fix cycle.
// Latency: fin high after accept edge + WIDTH+1 edges (accept edge + 1 on divide-by-zero).
// Backpressure: start is ignored while busy; results are held until the next completed operation.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             fin,
   output logic             div_zero
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count;
   logic [WIDTH:0]   rem_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] dvd_raw;
   logic             sign_q, sign_r;

   logic [WIDTH:0]   rem_nxt;
   logic             q_bit;
   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;

   // Operand magnitudes; MIN negates to 2^(WIDTH-1), which is still exact as an unsigned WIDTH-bit value
   always_comb begin
      dvd_neg = is_signed & dividend_in[WIDTH-1];
      dvs_neg = is_signed & divisor_in[WIDTH-1];
      dvd_mag = dvd_neg ? -dividend_in : dividend_in;
      dvs_mag = dvs_neg ? -divisor_in  : divisor_in;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .r       (rem_r),
      .q_msb   (q_r[WIDTH-1]),
      .divisor (dvs_r),
      .r_next  (rem_nxt),
      .q_bit   (q_bit)
   );

   // Sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; a zero divisor skips the bit loop and goes straight to the result cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (divisor_in == '0) ? FIX : RUN;
         RUN:     if (count == CNT_LAST) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and registered outputs, driven by the current state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         rem_r     <= '0;
         q_r       <= '0;
         dvs_r     <= '0;
         dvd_raw   <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         fin       <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  count    <= '0;
                  rem_r    <= '0;
                  q_r      <= dvd_mag;
                  dvs_r    <= dvs_mag;
                  dvd_raw  <= dividend_in;
                  sign_q   <= dvd_neg ^ dvs_neg;
                  sign_r   <= dvd_neg;
                  busy     <= 1'b1;
                  fin      <= 1'b0;
                  div_zero <= (divisor_in == '0);
               end
            end
            RUN: begin
               rem_r <= rem_nxt;
               q_r   <= {q_r[WIDTH-2:0], q_bit};
               count <= count + 1'b1;
            end
            FIX: begin
               fin <= 1'b1;
               if (div_zero) begin
                  quotient  <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                  remainder <= dvd_raw;
               end else begin
                  quotient  <= sign_q ? -q_r : q_r;
                  remainder <= sign_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
               end
            end
            DONE: begin
               fin  <= 1'b0;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32) with hand-computed expected values.
// Checks reset values, signed/unsigned results, divide-by-zero, MIN/-1, busy-start rejection,
// back-to-back starts, mid-operation reset and latency.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend_in;
   logic [31:0] divisor_in;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        fin;
   logic        div_zero;

   int checks = 0;
   int errors = 0;

   seq_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .dividend_in (dividend_in),
      .divisor_in  (divisor_in),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .fin         (fin),
      .div_zero    (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) until the divider is idle again
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Present operands with start for exactly one accept edge (E0); returns #1 after E0
   task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      wait_idle();
      @(negedge clk);
      start       = 1'b1;
      is_signed   = sgn;
      dividend_in = a;
      divisor_in  = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Count edges until fin is seen (bounded); lat=100 means it never came
   task automatic wait_fin(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!fin && lat < 100);
   endtask

   initial begin
      int lat;
      int lat2;
      int fin_seen;

      rst         = 1'b1;
      start       = 1'b0;
      is_signed   = 1'b0;
      dividend_in = '0;
      divisor_in  = '0;

      // Reset state
      #12;
      check("rst_quotient",  quotient,  32'h0);
      check("rst_remainder", remainder, 32'h0);
      check("rst_busy",      {31'h0, busy},     32'h0);
      check("rst_fin",       {31'h0, fin},      32'h0);
      check("rst_div_zero",  {31'h0, div_zero}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // 1: unsigned 100/7, latency and single-cycle fin
      issue(1'b0, 32'd100, 32'd7);
      wait_fin(lat);
      check("t1_latency",  lat, 32'd33);
      check("t1_quotient", quotient,  32'd14);
      check("t1_remainder", remainder, 32'd2);
      check("t1_div_zero", {31'h0, div_zero}, 32'h0);
      @(posedge clk); #1;
      check("t1_fin_pulse", {31'h0, fin},  32'h0);
      check("t1_busy_low",  {31'h0, busy}, 32'h0);

      // 2: -7/2 signed, then the same bits unsigned
      issue(1'b1, 32'hFFFF_FFF9, 32'h2);
      wait_fin(lat);
      check("t2s_quotient",  quotient,  32'hFFFF_FFFD);
      check("t2s_remainder", remainder, 32'hFFFF_FFFF);
      issue(1'b0, 32'hFFFF_FFF9, 32'h2);
      wait_fin(lat);
      check("t2u_quotient",  quotient,  32'h7FFF_FFFC);
      check("t2u_remainder", remainder, 32'h1);

      // 3: divide by zero
      issue(1'b0, 32'd5, 32'd0);
      wait_fin(lat);
      check("t3_latency",   lat, 32'd1);
      check("t3_quotient",  quotient,  32'hFFFF_FFFF);
      check("t3_remainder", remainder, 32'd5);
      check("t3_div_zero",  {31'h0, div_zero}, 32'h1);
      @(posedge clk); #1;
      check("t3_busy_low",  {31'h0, busy}, 32'h0);

      // 4: signed MIN / -1
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_fin(lat);
      check("t4_quotient",  quotient,  32'h8000_0000);
      check("t4_remainder", remainder, 32'h0);
      check("t4_div_zero",  {31'h0, div_zero}, 32'h0);

      // 5: start pulsed while busy is ignored; then start held gives back-to-back 9/9
      issue(1'b0, 32'd1000, 32'd3);
      dividend_in = 32'd9;
      divisor_in  = 32'd9;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_fin(lat);
      check("t5_latency",   lat + 5, 32'd33);
      check("t5_quotient",  quotient,  32'd333);
      check("t5_remainder", remainder, 32'd1);
      start = 1'b1;
      wait_fin(lat2);
      start = 1'b0;
      check("t5_b2b_latency",   lat2, 32'd35);
      check("t5_b2b_quotient",  quotient,  32'd1);
      check("t5_b2b_remainder", remainder, 32'd0);
      wait_idle();

      // 6: reset at E10 of a division clears outputs at once, no fin follows
      issue(1'b0, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      rst = 1'b1;
      #1;
      check("t6_quotient",  quotient,  32'h0);
      check("t6_remainder", remainder, 32'h0);
      check("t6_busy",      {31'h0, busy},     32'h0);
      check("t6_fin",       {31'h0, fin},      32'h0);
      check("t6_div_zero",  {31'h0, div_zero}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      fin_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (fin || busy) fin_seen++;
      end
      check("t6_no_fin", fin_seen, 32'd0);
      issue(1'b0, 32'd6, 32'd4);
      wait_fin(lat);
      check("t6_quotient_after",  quotient,  32'd1);
      check("t6_remainder_after", remainder, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
